// File: rtl/txarbiter.sv
// Round-robin arbiter sharing one word serializer among NS strobe/ack sources.
// One winner is captured per IDLE cycle; the next grant waits until the serializer is idle again.
module txarbiter #(
  parameter int NS = 4,
  parameter int DW = 32
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [NS-1:0]  i_stb,
  input  logic [NS*DW-1:0] i_data,
  output logic [NS-1:0]  o_ack,
  output logic           o_tx_stb,
  output logic [DW-1:0]  o_tx_data,
  input  logic           i_tx_busy,
  output logic [2:0]     o_grant,
  output logic           o_active
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_e;

  state_e          state_q, state_d;
  logic            txStb_q, txStb_d;
  logic [DW-1:0]   txData_q, txData_d;
  logic [NS-1:0]   ack_q, ack_d;
  logic [2:0]      grant_q, grant_d;

  logic [7:0]      stbExt;
  logic [2:0]      idx;
  logic [2:0]      winner;
  logic            found;
  logic [DW-1:0]   winData;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    stbExt = 8'(i_stb);
    idx    = grant_q;
    winner = grant_q;
    found  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      idx = (idx == 3'(NS - 1)) ? 3'd0 : idx + 3'd1;
      if (!found && stbExt[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    winData = '0;
    for (int k = 0; k < NS; k++) begin
      if (winner == 3'(k)) begin
        winData = i_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    txStb_d  = txStb_q;
    txData_d = txData_q;
    ack_d    = '0;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (|i_stb) begin
          state_d  = SEND;
          txStb_d  = 1'b1;
          txData_d = winData;
          grant_d  = winner;
          for (int k = 0; k < NS; k++) begin
            ack_d[k] = (winner == 3'(k));
          end
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          txStb_d = 1'b0;
          state_d = HOLD;
        end
      end
      // Serializer busy is registered and only rises the cycle after acceptance.
      HOLD: state_d = WAIT;
      WAIT: begin
        if (!i_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      txStb_q  <= 1'b0;
      txData_q <= '0;
      ack_q    <= '0;
      grant_q  <= 3'(NS - 1);
    end else begin
      state_q  <= state_d;
      txStb_q  <= txStb_d;
      txData_q <= txData_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_tx_stb  = txStb_q;
  assign o_tx_data = txData_q;
  assign o_grant   = grant_q;
  assign o_active  = (state_q != IDLE);

endmodule
